instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 4'h0, sets the program counter value loaded on reset.
REQ-002 Parameter HALT_OPCODE, default 8'hFF, is the instruction byte that stops sequential fetching.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  run enable; when 0, no new fetch is started.
REQ-006 jump  input  1  load PC from jump_addr; single-cycle pulse.
REQ-007 jump_addr  input  4  jump target address.
REQ-008 mem_addr  output  4  address to the 16x8 program memory.
REQ-009 mem_rd  output  1  memory read strobe; memory returns data registered one cycle later.
REQ-010 mem_wr  output  1  memory write strobe; held 0 by this block.
REQ-011 mem_dout  input  8  read data from memory, valid the cycle after mem_rd.
REQ-012 ir  output  8  fetched instruction register.
REQ-013 ir_valid  output  1  ir holds an undelivered instruction.
REQ-014 ir_ready  input  1  downstream decode accepts ir when ir_valid && ir_ready.
REQ-015 pc  output  4  address of the instruction currently in ir or being fetched.
REQ-016 halted  output  1  high while in HALT state.

Function
REQ-017 The FSM SHALL have the states IDLE, REQ, CAP, VALID and HALT.
- IDLE: en=1 -> REQ.
- REQ: mem_rd=1, mem_addr=pc -> CAP.
- CAP: ir<=mem_dout -> VALID.
- VALID: ir_valid=1; handshake -> HALT if ir==HALT_OPCODE, else pc<=pc+1 and REQ if en else IDLE; no handshake -> stay.
- HALT: only jump exits.
REQ-018 Latency from leaving IDLE to ir_valid=1 SHALL be exactly 3 cycles (REQ, CAP, then VALID).
REQ-019 mem_rd SHALL be 1 only in REQ, and mem_addr SHALL equal pc in every state.
REQ-020 ir SHALL be stable while ir_valid=1, and ir_valid SHALL drop the cycle after a handshake.
REQ-021 PC increment SHALL wrap modulo 16 (4'hF -> 4'h0), with no flag or stall at the wrap.
REQ-022 jump in any state SHALL load pc<=jump_addr, discard any in-flight fetch or undelivered ir (ir_valid<=0), clear HALT, and go to REQ if en else IDLE.
REQ-023 jump SHALL take priority over a simultaneous handshake; the handshaken instruction counts as delivered and pc takes jump_addr, not pc+1.
REQ-024 Deasserting en SHALL NOT abort a fetch already in REQ, CAP or VALID; it only prevents the next REQ.
REQ-025 halted SHALL be 1 exactly while the state is HALT; en has no effect in HALT.

Reset
REQ-026 On reset low, the block SHALL immediately set state=IDLE, pc=RESET_PC, ir=8'h00, ir_valid=0, mem_rd=0, mem_wr=0 and halted=0.
REQ-027 Reset asserted mid-fetch SHALL abandon the fetch with no further mem_rd, and the first fetch after release SHALL use RESET_PC.
REQ-028 Every register SHALL have a reset value, and none SHALL be loaded from memory contents at reset.

Structure
REQ-029 The shared package cpu_pkg SHALL hold ADDR_W=4, DATA_W=8, the fetch state enum and the HALT_OPCODE default constant.
REQ-030 The PC SHALL be a sub-module pc_reg (load, increment, wrap, async reset), instantiated once.
REQ-031 All outputs SHALL be registered or decoded from the state register only, with no combinational path from ir_ready to mem_rd.

Verification
REQ-032 Memory 0..2 = 8'h11, 8'h22, 8'h33, en=1, ir_ready=1 -> mem_rd at addresses 0, 1, 2 spaced 3 cycles apart; ir sequence 11, 22, 33; first ir_valid on cycle 3 after reset release.
REQ-033 ir_ready=0 for 5 cycles with ir=8'h22 -> ir_valid stays 1, ir stays 8'h22, no mem_rd; after ready, pc=2.
REQ-034 Start with jump_addr=4'hE, mem[14]=8'h01, mem[15]=8'h02, mem[0]=8'h03 -> ir sequence 01, 02, 03; pc wraps F->0.
REQ-035 mem[3]=8'hFF -> after its handshake, halted=1 and no mem_rd for 10 cycles; jump to 4'h5 -> halted=0, mem_rd at address 5.
REQ-036 jump to 4'h9 in the same cycle as a handshake at pc=4 -> next mem_rd address 9, not 5.
REQ-037 Reset pulsed during CAP -> ir=8'h00, ir_valid=0, pc=RESET_PC; after release, fetch restarts at address 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, fetch FSM state encoding and default constants
// for the instruction fetch path.
//   ADDR_W              program memory address width (16 entries)
//   DATA_W              instruction byte width
//   fetch_state_t       fetch FSM states
//   HALT_OPCODE_DEFAULT instruction byte that stops sequential fetching
package cpu_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] HALT_OPCODE_DEFAULT = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_CAP   = 3'd2,
        ST_VALID = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with load and increment. The increment wraps
// modulo 2**ADDR_W naturally; load has priority over increment.
//   clk        system clock
//   reset      asynchronous active-low reset, loads RESET_PC
//   load       load pc from load_addr
//   load_addr  value to load
//   inc        advance pc by one
//   pc         current program counter
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 4'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetches instruction bytes from a 16x8 synchronous-read
// program memory and offers them to decode with a valid/ready handshake.
//   clk        system clock
//   reset      asynchronous active-low reset
//   en         run enable; gates the start of a new fetch only
//   jump       single-cycle pulse: pc <= jump_addr, drop any fetch
//   jump_addr  jump target
//   mem_addr   memory address (always equals pc)
//   mem_rd     memory read strobe (data returns one cycle later)
//   mem_wr     memory write strobe (never asserted)
//   mem_dout   memory read data
//   ir         fetched instruction
//   ir_valid   ir holds an undelivered instruction
//   ir_ready   decode accepts ir
//   pc         address of the instruction in ir or being fetched
//   halted     high while halted on HALT_OPCODE
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = 4'h0,
    parameter logic [DATA_W-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] ir_d;
    logic              pc_load;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc_cur;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (pc_load),
        .load_addr (jump_addr),
        .inc       (pc_inc),
        .pc        (pc_cur)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        if (jump) begin
            // A jump overrides everything, including a handshake in the
            // same cycle: that instruction is delivered but pc takes the
            // jump target rather than pc+1.
            pc_load = 1'b1;
            state_d = en ? ST_REQ : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    state_d = ST_CAP;
                end
                ST_CAP: begin
                    ir_d    = mem_dout;
                    state_d = ST_VALID;
                end
                ST_VALID: begin
                    if (ir_ready) begin
                        if (ir_q == HALT_OPCODE) begin
                            // pc stays on the halt instruction
                            state_d = ST_HALT;
                        end else begin
                            pc_inc  = 1'b1;
                            state_d = en ? ST_REQ : ST_IDLE;
                        end
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Outputs come straight from registers so ir_ready never reaches mem_rd
    // combinationally.
    assign mem_rd   = (state_q == ST_REQ);
    assign ir_valid = (state_q == ST_VALID);
    assign halted   = (state_q == ST_HALT);
    assign mem_wr   = 1'b0;
    assign mem_addr = pc_cur;
    assign pc       = pc_cur;
    assign ir       = ir_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven cycle checks, directed corner sequences and
// a randomized run against a transaction-level scoreboard.
module tb_instr_fetch;

    logic       clk;
    logic       reset;
    logic       en;
    logic       jump;
    logic [3:0] jump_addr;
    logic [3:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_dout;
    logic [7:0] ir;
    logic       ir_valid;
    logic       ir_ready;
    logic [3:0] pc;
    logic       halted;

    logic [7:0] mem [16];

    int checks = 0;
    int errors = 0;

    instr_fetch #(
        .RESET_PC    (4'h0),
        .HALT_OPCODE (8'hFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .jump      (jump),
        .jump_addr (jump_addr),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_dout  (mem_dout),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .pc        (pc),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read program memory model
    initial mem_dout = 8'h00;
    always @(posedge clk) begin
        if (mem_rd) mem_dout <= mem[mem_addr];
    end

    typedef struct packed {
        logic        en;
        logic        rdy;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] pk(input logic rd, input logic [3:0] a, input logic v,
                                       input logic [7:0] i, input logic [3:0] p, input logic h);
        return {1'b0, rd, a, v, i, p, h};
    endfunction

    function automatic vec_t mk(input logic e, input logic r, input logic rd, input logic [3:0] a,
                                input logic v, input logic [7:0] i, input logic [3:0] p);
        vec_t t;
        t.en  = e;
        t.rdy = r;
        t.exp = pk(rd, a, v, i, p, 1'b0);
        return t;
    endfunction

    // Leaves the bench at a negedge with reset just released, DUT idle.
    task automatic do_reset();
        en        = 1'b0;
        ir_ready  = 1'b0;
        jump      = 1'b0;
        jump_addr = 4'h0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_valid_at(input logic [3:0] p, input int bound, output bit found);
        found = 1'b0;
        for (int c = 0; c < bound; c++) begin
            if (ir_valid && pc == p) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bit         found;
        bit         bad;
        int         n;
        int         cyc;
        logic [7:0] got_ir [3];
        logic [3:0] got_pc [3];
        logic [7:0] exp_ir [3];
        logic [3:0] exp_pc3 [3];
        logic [3:0] exp_pc;
        logic       halted_m;
        logic       prev_hold;
        logic       prev_clear;
        logic [7:0] prev_ir;
        int         halt_cnt;
        int         hs_n;
        logic       hs;

        reset     = 1'b0;
        en        = 1'b0;
        ir_ready  = 1'b0;
        jump      = 1'b0;
        jump_addr = 4'h0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // ---------------- table: basic fetch, stall, en drop ----------------
        tbl[0]  = mk(1, 1, 0, 4'h0, 0, 8'h00, 4'h0);
        tbl[1]  = mk(1, 1, 1, 4'h0, 0, 8'h00, 4'h0);
        tbl[2]  = mk(1, 1, 0, 4'h0, 0, 8'h00, 4'h0);
        tbl[3]  = mk(1, 1, 0, 4'h0, 1, 8'h11, 4'h0);
        tbl[4]  = mk(1, 1, 1, 4'h1, 0, 8'h11, 4'h1);
        tbl[5]  = mk(1, 1, 0, 4'h1, 0, 8'h11, 4'h1);
        for (int r = 6; r <= 10; r++) tbl[r] = mk(1, 0, 0, 4'h1, 1, 8'h22, 4'h1);
        tbl[11] = mk(1, 1, 0, 4'h1, 1, 8'h22, 4'h1);
        tbl[12] = mk(1, 1, 1, 4'h2, 0, 8'h22, 4'h2);
        tbl[13] = mk(1, 1, 0, 4'h2, 0, 8'h22, 4'h2);
        tbl[14] = mk(1, 1, 0, 4'h2, 1, 8'h33, 4'h2);
        tbl[15] = mk(0, 1, 1, 4'h3, 0, 8'h33, 4'h3);
        tbl[16] = mk(0, 1, 0, 4'h3, 0, 8'h33, 4'h3);
        tbl[17] = mk(0, 1, 0, 4'h3, 1, 8'h44, 4'h3);
        tbl[18] = mk(0, 1, 0, 4'h4, 0, 8'h44, 4'h4);
        tbl[19] = mk(1, 1, 0, 4'h4, 0, 8'h44, 4'h4);
        tbl[20] = mk(1, 1, 1, 4'h4, 0, 8'h44, 4'h4);

        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44; mem[4] = 8'h55;
        do_reset();
        for (int r = 0; r < 21; r++) begin
            chk($sformatf("table_row%0d", r),
                32'({mem_wr, mem_rd, mem_addr, ir_valid, ir, pc, halted}), 32'(tbl[r].exp));
            $display("row %0d: rd=%0b addr=%0h valid=%0b ir=%02h pc=%0h", r, mem_rd, mem_addr, ir_valid, ir, pc);
            en       = tbl[r].en;
            ir_ready = tbl[r].rdy;
            @(negedge clk);
        end

        // ---------------- wrap F -> 0 after jump to E ----------------
        mem[14] = 8'h01; mem[15] = 8'h02; mem[0] = 8'h03; mem[1] = 8'h04;
        exp_ir[0] = 8'h01; exp_ir[1] = 8'h02; exp_ir[2] = 8'h03;
        exp_pc3[0] = 4'hE; exp_pc3[1] = 4'hF; exp_pc3[2] = 4'h0;
        do_reset();
        jump = 1'b1; jump_addr = 4'hE; en = 1'b1; ir_ready = 1'b1;
        @(negedge clk);
        jump = 1'b0;
        n = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            if (ir_valid) begin
                got_ir[n] = ir;
                got_pc[n] = pc;
                $display("wrap: delivered ir=%02h pc=%0h", ir, pc);
                n++;
            end
            @(negedge clk);
        end
        chk("wrap_count", 32'(n), 32'd3);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("wrap_ir%0d", k), 32'(got_ir[k]), 32'(exp_ir[k]));
            chk($sformatf("wrap_pc%0d", k), 32'(got_pc[k]), 32'(exp_pc3[k]));
        end

        // ---------------- halt, then jump out ----------------
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'hFF;
        do_reset();
        en = 1'b1; ir_ready = 1'b1;
        wait_valid_at(4'h3, 40, found);
        chk("halt_reach", 32'(found), 32'd1);
        chk("halt_ir", 32'(ir), 32'hFF);
        @(negedge clk);
        chk("halt_set", 32'(halted), 32'd1);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mem_rd || !halted) bad = 1'b1;
        end
        chk("halt_quiet", 32'(bad), 32'd0);
        jump = 1'b1; jump_addr = 4'h5;
        @(negedge clk);
        jump = 1'b0;
        $display("halt exit: halted=%0b rd=%0b addr=%0h", halted, mem_rd, mem_addr);
        chk("halt_clear", 32'(halted), 32'd0);
        chk("halt_jump_rd", 32'({mem_rd, mem_addr}), 32'h15);

        // ---------------- jump vs simultaneous handshake ----------------
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44; mem[4] = 8'h55;
        do_reset();
        en = 1'b1; ir_ready = 1'b1;
        wait_valid_at(4'h4, 60, found);
        chk("prio_reach", 32'(found), 32'd1);
        jump = 1'b1; jump_addr = 4'h9;
        @(negedge clk);
        jump = 1'b0;
        $display("prio: pc=%0h rd=%0b addr=%0h", pc, mem_rd, mem_addr);
        chk("prio_pc", 32'(pc), 32'h9);
        chk("prio_rd", 32'({mem_rd, mem_addr}), 32'h19);
        chk("prio_valid", 32'(ir_valid), 32'd0);

        // ---------------- reset during CAP ----------------
        do_reset();
        en = 1'b1; ir_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (mem_rd && pc == 4'h1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_reach", 32'(found), 32'd1);
        @(negedge clk);
        chk("rst_precap_ir", 32'(ir), 32'h11);
        reset = 1'b0;
        #1;
        chk("rst_state", 32'({ir, ir_valid, pc, mem_rd, halted, mem_wr}), 32'h0);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (mem_rd) bad = 1'b1;
        end
        chk("rst_no_rd", 32'(bad), 32'd0);
        reset = 1'b1;
        cyc = 0;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            cyc++;
            if (mem_rd) begin
                found = 1'b1;
                break;
            end
        end
        $display("reset restart: rd after %0d cycles at addr=%0h", cyc, mem_addr);
        chk("rst_restart_found", 32'(found), 32'd1);
        chk("rst_restart_addr", 32'(mem_addr), 32'h0);
        chk("rst_restart_lat", 32'(cyc), 32'd1);

        // ---------------- randomized run with scoreboard ----------------
        for (int i = 0; i < 16; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        do_reset();
        exp_pc     = 4'h0;
        halted_m   = 1'b0;
        prev_hold  = 1'b0;
        prev_clear = 1'b0;
        prev_ir    = 8'h00;
        halt_cnt   = 0;
        hs_n       = 0;
        for (int c = 0; c < 800; c++) begin
            chk("rnd_pc", 32'(pc), 32'(exp_pc));
            chk("rnd_halted", 32'(halted), 32'(halted_m));
            chk("rnd_wr", 32'(mem_wr), 32'd0);
            if (mem_rd) chk("rnd_rd_addr", 32'(mem_addr), 32'(exp_pc));
            if (halted_m) chk("rnd_halt_no_rd", 32'(mem_rd), 32'd0);
            if (prev_hold) chk("rnd_hold", 32'({ir_valid, ir}), 32'({1'b1, prev_ir}));
            if (prev_clear) chk("rnd_valid_drop", 32'(ir_valid), 32'd0);

            halt_cnt  = halted_m ? halt_cnt + 1 : 0;
            en        = ($urandom_range(0, 3) != 0);
            ir_ready  = ($urandom_range(0, 1) != 0);
            jump      = ($urandom_range(0, 19) == 0) || (halt_cnt > 5);
            jump_addr = 4'($urandom_range(0, 15));

            hs = ir_valid && ir_ready;
            if (hs) begin
                chk("rnd_ir", 32'(ir), 32'(mem[exp_pc]));
                hs_n++;
            end
            prev_hold  = ir_valid && !ir_ready && !jump;
            prev_ir    = ir;
            prev_clear = hs || jump;
            if (hs && !jump) begin
                if (mem[exp_pc] == 8'hFF) halted_m = 1'b1;
                else exp_pc = exp_pc + 4'h1;
            end
            if (jump) begin
                exp_pc   = jump_addr;
                halted_m = 1'b0;
            end
            @(negedge clk);
        end
        jump = 1'b0;
        $display("random run: %0d instructions delivered", hs_n);
        chk("rnd_progress", 32'(hs_n >= 40), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
